// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: merges single-cycle ALU results with an
// in-order FIFO of load results and reports pending-write hazards to decode.
module writeback_arbiter #(
  parameter int XLEN     = 32,
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_BITS-1:0]          alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [REG_BITS-1:0]          ld_rd,
  input  logic [XLEN-1:0]              ld_data,
  output logic                         write_en,
  output logic [REG_BITS-1:0]          write_ptr,
  output logic [XLEN-1:0]              write_data,
  input  logic [REG_BITS-1:0]          query_a_ptr,
  input  logic [REG_BITS-1:0]          query_b_ptr,
  output logic                         hazard_a,
  output logic                         hazard_b,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [REG_BITS-1:0] rd_q   [DEPTH];
  logic [XLEN-1:0]     data_q [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [PW-1:0]       head_q, head_d;
  logic [PW-1:0]       tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  logic                we_q, we_d;
  logic [REG_BITS-1:0] ptr_q, ptr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;

  logic full;
  logic alu_fire;
  logic push;
  logic pop;

  // A full FIFO forces a pop so loads cannot be starved by a busy ALU.
  // The pop decision uses the pre-push count, so a load never bypasses the FIFO.
  always_comb begin
    full      = (count_q == CW'(DEPTH));
    alu_ready = reset_n && !full;
    ld_ready  = reset_n && !full;
    alu_fire  = alu_valid && alu_ready;
    push      = ld_valid && ld_ready && (ld_rd != '0);
    pop       = reset_n && (full || (!alu_valid && (count_q != '0)));
  end

  always_comb begin
    we_d    = 1'b0;
    ptr_d   = ptr_q;
    wdata_d = wdata_q;
    if (alu_fire) begin
      if (alu_rd != '0) begin
        we_d    = 1'b1;
        ptr_d   = alu_rd;
        wdata_d = alu_data;
      end
    end else if (pop) begin
      we_d    = valid_q[head_q];
      ptr_d   = rd_q[head_q];
      wdata_d = data_q[head_q];
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
    end
    head_d  = pop  ? head_q + PW'(1) : head_q;
    tail_d  = push ? tail_q + PW'(1) : tail_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      ptr_q   <= '0;
      wdata_q <= '0;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      we_q    <= we_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every entry.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail_q]   <= ld_rd;
      data_q[tail_q] <= ld_data;
    end
  end

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == query_a_ptr)) hazard_a = 1'b1;
      if (valid_q[i] && (rd_q[i] == query_b_ptr)) hazard_b = 1'b1;
    end
    if (we_q && (ptr_q == query_a_ptr)) hazard_a = 1'b1;
    if (we_q && (ptr_q == query_b_ptr)) hazard_b = 1'b1;
    if (query_a_ptr == '0) hazard_a = 1'b0;
    if (query_b_ptr == '0) hazard_b = 1'b0;
  end

  assign write_en   = we_q;
  assign write_ptr  = ptr_q;
  assign write_data = wdata_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked against a queue-based model.
module tb_writeback_arbiter;

  localparam int XLEN     = 32;
  localparam int REG_BITS = 5;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                alu_valid, alu_ready;
  logic [REG_BITS-1:0] alu_rd;
  logic [XLEN-1:0]     alu_data;
  logic                ld_valid, ld_ready;
  logic [REG_BITS-1:0] ld_rd;
  logic [XLEN-1:0]     ld_data;
  logic                write_en;
  logic [REG_BITS-1:0] write_ptr;
  logic [XLEN-1:0]     write_data;
  logic [REG_BITS-1:0] query_a_ptr, query_b_ptr;
  logic                hazard_a, hazard_b;
  logic [2:0]          fifo_count;

  always #5 clk = ~clk;

  writeback_arbiter #(.XLEN(XLEN), .REG_BITS(REG_BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .write_en(write_en), .write_ptr(write_ptr), .write_data(write_data),
    .query_a_ptr(query_a_ptr), .query_b_ptr(query_b_ptr),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .fifo_count(fifo_count)
  );

  int compared   = 0;
  int mismatched = 0;
  bit checkEn    = 1'b0;

  typedef struct {
    logic [REG_BITS-1:0] rd;
    logic [XLEN-1:0]     data;
  } entry_t;

  // Model state after the most recent rising edge.
  entry_t              mq[$];
  logic                mEn   = 1'b0;
  logic [REG_BITS-1:0] mPtr  = '0;
  logic [XLEN-1:0]     mData = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic applyStimulus(input bit av, input logic [REG_BITS-1:0] ard, input logic [XLEN-1:0] ad,
                               input bit lv, input logic [REG_BITS-1:0] lrd, input logic [XLEN-1:0] ldd,
                               input bit rn);
    alu_valid = av;
    alu_rd    = ard;
    alu_data  = ad;
    ld_valid  = lv;
    ld_rd     = lrd;
    ld_data   = ldd;
    reset_n   = rn;
  endtask

  function automatic bit modelHazard(input logic [REG_BITS-1:0] q);
    if (q == '0) return 1'b0;
    if (mEn && mPtr == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  // Inputs are stable at the falling edge, so compare here and then advance
  // the model with the inputs the next rising edge will sample.
  always @(negedge clk) begin
    bit     full;
    entry_t e;
    if (checkEn) begin
      full = (mq.size() == DEPTH);
      checkOutput("alu_ready", alu_ready, reset_n && !full);
      checkOutput("ld_ready", ld_ready, reset_n && !full);
      checkOutput("write_en", write_en, mEn);
      if (mEn) begin
        checkOutput("write_ptr", write_ptr, mPtr);
        checkOutput("write_data", write_data, mData);
      end
      checkOutput("fifo_count", fifo_count, mq.size());
      checkOutput("hazard_a", hazard_a, modelHazard(query_a_ptr));
      checkOutput("hazard_b", hazard_b, modelHazard(query_b_ptr));

      if (!reset_n) begin
        mq.delete();
        mEn   = 1'b0;
        mPtr  = '0;
        mData = '0;
      end else begin
        if (full) begin
          e = mq.pop_front();
          mEn = 1'b1; mPtr = e.rd; mData = e.data;
        end else if (alu_valid) begin
          mEn = (alu_rd != '0);
          if (alu_rd != '0) begin
            mPtr = alu_rd; mData = alu_data;
          end
        end else if (mq.size() > 0) begin
          e = mq.pop_front();
          mEn = 1'b1; mPtr = e.rd; mData = e.data;
        end else begin
          mEn = 1'b0;
        end
        if (ld_valid && !full && ld_rd != '0) begin
          e.rd = ld_rd; e.data = ld_data;
          mq.push_back(e);
        end
      end
    end
  end

  initial begin
    bit aF, lF;
    query_a_ptr = '0;
    query_b_ptr = '0;

    // Reset held for two edges with both sources offering results.
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0);
    @(posedge clk); #1;
    checkEn = 1'b1;
    @(negedge clk);
    checkOutput("rst_write_en", write_en, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_alu_ready", alu_ready, 0);
    checkOutput("rst_ld_ready", ld_ready, 0);
    checkOutput("rst_write_ptr", write_ptr, 0);
    checkOutput("rst_write_data", write_data, 0);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("rel_ld_ready", ld_ready, 1);

    // Single ALU result.
    @(posedge clk); #1;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("alu_we", write_en, 1);
    checkOutput("alu_ptr", write_ptr, 5);
    checkOutput("alu_data", write_data, 32'hDEADBEEF);
    @(negedge clk);
    checkOutput("alu_we_off", write_en, 0);

    // Single load: two-cycle latency and hazard window.
    @(posedge clk); #1;
    query_a_ptr = 5'd7;
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd7, 32'h00001234, 1'b1);
    @(negedge clk);
    checkOutput("ld_haz_before", hazard_a, 0);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("ld_haz_queued", hazard_a, 1);
    checkOutput("ld_we_early", write_en, 0);
    checkOutput("ld_count", fifo_count, 1);
    @(negedge clk);
    checkOutput("ld_we", write_en, 1);
    checkOutput("ld_ptr", write_ptr, 7);
    checkOutput("ld_data", write_data, 32'h00001234);
    checkOutput("ld_haz_write", hazard_a, 1);
    @(negedge clk);
    checkOutput("ld_haz_after", hazard_a, 0);

    // Starvation guard: ALU kept busy while four loads fill the FIFO.
    @(posedge clk); #1;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, REG_BITS'(k), 32'(100 + k), 1'b1);
      @(posedge clk); #1;
    end
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("full_count", fifo_count, 4);
    checkOutput("full_ld_ready", ld_ready, 0);
    checkOutput("full_alu_ready", alu_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("starve_we", write_en, 1);
    checkOutput("starve_ptr", write_ptr, 1);
    checkOutput("starve_data", write_data, 101);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("starve_alu_ptr", write_ptr, 9);
    checkOutput("starve_count", fifo_count, 3);
    repeat (6) begin @(posedge clk); #1; end

    // x0 destinations are accepted but never written.
    query_a_ptr = '0;
    applyStimulus(1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 1'b1);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("x0_we", write_en, 0);
    checkOutput("x0_count", fifo_count, 0);
    checkOutput("x0_haz", hazard_a, 0);
    @(negedge clk);
    checkOutput("x0_we_later", write_en, 0);

    // Reset with three loads queued.
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, REG_BITS'(10 + k), 32'(k), 1'b1);
      @(posedge clk); #1;
    end
    query_a_ptr = 5'd10;
    query_b_ptr = 5'd12;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    @(negedge clk);
    checkOutput("mid_count_pre", fifo_count, 3);
    checkOutput("mid_haz_pre", hazard_a, 1);
    @(posedge clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    @(negedge clk);
    checkOutput("mid_count", fifo_count, 0);
    checkOutput("mid_we", write_en, 0);
    checkOutput("mid_haz_a", hazard_a, 0);
    checkOutput("mid_haz_b", hazard_b, 0);
    repeat (3) begin @(posedge clk); #1; end

    // Randomized traffic; an offered result holds until it is accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      aF = alu_valid && alu_ready;
      lF = ld_valid && ld_ready;
      @(posedge clk); #1;
      if (!alu_valid || aF) begin
        alu_valid = ($urandom % 100) < 45;
        alu_rd    = REG_BITS'($urandom % 8);
        alu_data  = $urandom;
      end
      if (!ld_valid || lF) begin
        ld_valid = ($urandom % 100) < 60;
        ld_rd    = REG_BITS'($urandom % 8);
        ld_data  = $urandom;
      end
      reset_n     = ($urandom % 64) != 0;
      query_a_ptr = REG_BITS'($urandom % 8);
      query_b_ptr = REG_BITS'($urandom % 8);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
